// File: rtl/keyboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keyboard_pkg
// Description : Shared types for the keyboard matrix scanner: FSM state
//               encoding and the per-sweep result record.
// Revision    : 1.0 - initial release
// ============================================================================
package keyboard_pkg;

    // Sweep code field is sized for matrices of up to 256 keys.
    localparam int c_code_max_w = 8;

    typedef enum logic [1:0] {
        KB_IDLE     = 2'd0,
        KB_DEBOUNCE = 2'd1,
        KB_HELD     = 2'd2,
        KB_RELEASE  = 2'd3
    } kb_state_t;

    typedef struct packed {
        logic                    hit;
        logic                    multi;
        logic [c_code_max_w-1:0] code;
        logic                    cand_seen;
    } kb_sweep_t;

endpackage
`default_nettype wire

// File: rtl/keyboard_sweep.sv
`default_nettype none
// ============================================================================
// Module      : keyboard_sweep
// Description : Row synchronizer, strobe edge detection, column sequencing and
//               per-sweep accumulation of pressed keys.
// Revision    : 1.0 - initial release
// ============================================================================
module keyboard_sweep
    import keyboard_pkg::*;
#(
    parameter int COLS   = 8,
    parameter int ROWS   = 4,
    parameter int COL_W  = $clog2(COLS),
    parameter int CODE_W = $clog2(COLS*ROWS)
) (
    input  logic              Clock_1us,
    input  logic              Rst_n,
    input  logic              keyboard_write,
    input  logic              keyboard_read,
    input  logic [ROWS-1:0]   kb_row_n,
    input  logic [CODE_W-1:0] cand,
    output logic [COL_W-1:0]  kb_col,
    output logic              sweep_done,
    output kb_sweep_t         sweep_result
);

    localparam int c_row_w = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [ROWS-1:0]    r_row_s1;
    logic [ROWS-1:0]    r_row_s2;
    logic               r_wr_d;
    logic               r_rd_d;
    logic               r_armed;
    logic [COL_W-1:0]   r_col_idx;
    logic [COL_W-1:0]   r_kb_col;
    logic               r_sweep_done;
    kb_sweep_t          r_acc;
    kb_sweep_t          r_result;

    logic               w_wr_edge;
    logic               w_rd_edge;
    logic               w_sample;
    logic               w_last_col;
    logic [COL_W-1:0]   w_col_adv;
    logic [COL_W-1:0]   w_col_new;
    logic [ROWS-1:0]    w_pressed;
    logic               w_col_hit;
    logic               w_col_multi;
    logic               w_cand_hit;
    logic [c_row_w-1:0] w_low_row;
    logic [CODE_W-1:0]  w_col_code;
    kb_sweep_t          w_acc_nxt;

    assign w_wr_edge  = keyboard_write & ~r_wr_d;
    assign w_rd_edge  = keyboard_read & ~r_rd_d;
    assign w_sample   = w_rd_edge & r_armed;
    assign w_last_col = (r_kb_col == COL_W'(COLS-1));
    assign w_col_adv  = (r_col_idx == COL_W'(COLS-1)) ? '0 : r_col_idx + COL_W'(1);
    // A coincident read advances first, so the write latches the advanced index.
    assign w_col_new  = w_sample ? w_col_adv : r_col_idx;

    always_comb begin
        w_pressed   = ~r_row_s2;
        w_col_hit   = |w_pressed;
        w_col_multi = |(w_pressed & (w_pressed - ROWS'(1)));
        w_low_row   = '0;
        for (int i = ROWS-1; i >= 0; i--) begin
            if (w_pressed[i]) w_low_row = c_row_w'(i);
        end
        w_col_code = CODE_W'(r_kb_col) * CODE_W'(ROWS) + CODE_W'(w_low_row);
        w_cand_hit = (CODE_W'(r_kb_col) == cand / CODE_W'(ROWS))
                   && w_pressed[c_row_w'(cand % CODE_W'(ROWS))];

        // Columns arrive in ascending order, so the first hit is the lowest code.
        w_acc_nxt.hit       = r_acc.hit | w_col_hit;
        w_acc_nxt.multi     = r_acc.multi | w_col_multi | (r_acc.hit & w_col_hit);
        w_acc_nxt.code      = (r_acc.hit | ~w_col_hit) ? r_acc.code : c_code_max_w'(w_col_code);
        w_acc_nxt.cand_seen = r_acc.cand_seen | w_cand_hit;
    end

    always_ff @(posedge Clock_1us or negedge Rst_n) begin
        if (!Rst_n) begin
            r_row_s1     <= '1;
            r_row_s2     <= '1;
            r_wr_d       <= 1'b0;
            r_rd_d       <= 1'b0;
            r_armed      <= 1'b0;
            r_col_idx    <= '0;
            r_kb_col     <= '0;
            r_sweep_done <= 1'b0;
            r_acc        <= '0;
            r_result     <= '0;
        end else begin
            r_row_s1     <= kb_row_n;
            r_row_s2     <= r_row_s1;
            r_wr_d       <= keyboard_write;
            r_rd_d       <= keyboard_read;
            r_sweep_done <= 1'b0;
            if (w_sample) begin
                r_armed   <= 1'b0;
                r_col_idx <= w_col_adv;
                if (w_last_col) begin
                    r_result     <= w_acc_nxt;
                    r_sweep_done <= 1'b1;
                    r_acc        <= '0;
                end else begin
                    r_acc <= w_acc_nxt;
                end
            end
            if (w_wr_edge) begin
                r_kb_col <= w_col_new;
                r_armed  <= 1'b1;
            end
        end
    end

    assign kb_col       = r_kb_col;
    assign sweep_done   = r_sweep_done;
    assign sweep_result = r_result;

endmodule
`default_nettype wire

// File: rtl/keyboard_matrix_scan.sv
`default_nettype none
// ============================================================================
// Module      : keyboard_matrix_scan
// Description : Sequencer-driven key matrix scanner with sweep debouncing,
//               ghost rejection and a valid/ack key delivery port.
//               Optional autorepeat: define KEYBOARD_AUTOREPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module keyboard_matrix_scan
    import keyboard_pkg::*;
#(
    parameter int COLS                = 8,
    parameter int ROWS                = 4,
    parameter int DEBOUNCE_SWEEPS     = 3,
    parameter int REPEAT_DELAY_SWEEPS = 40,
    parameter int REPEAT_RATE_SWEEPS  = 8
) (
    input  logic                         Clock_1us,
    input  logic                         Rst_n,
    input  logic                         keyboard_write,
    input  logic                         keyboard_read,
    input  logic [ROWS-1:0]              kb_row_n,
    output logic [$clog2(COLS)-1:0]      kb_col,
    output logic [$clog2(COLS*ROWS)-1:0] key_code,
    output logic                         key_valid,
    input  logic                         key_ack,
    output logic                         key_overrun,
    output logic                         key_held
);

    localparam int c_col_w  = $clog2(COLS);
    localparam int c_code_w = $clog2(COLS*ROWS);
    localparam int c_cnt_w  = $clog2(DEBOUNCE_SWEEPS+1);

    kb_state_t           r_state;
    kb_state_t           w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;
    logic [c_cnt_w-1:0]  w_cnt_inc;
    logic [c_code_w-1:0] r_cand;
    logic [c_code_w-1:0] w_cand_nxt;
    logic [c_code_w-1:0] r_key_code;
    logic                r_key_valid;
    logic                r_key_overrun;

    logic                w_sweep_done;
    kb_sweep_t           w_sweep;
    logic                w_code_oob;
    logic                w_single;
    logic [c_code_w-1:0] w_sweep_code;
    logic                w_accept;
    logic                w_repeat;
    logic                w_emit;
    logic [c_code_w-1:0] w_emit_code;

    keyboard_sweep #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .COL_W  (c_col_w),
        .CODE_W (c_code_w)
    ) u_sweep (
        .Clock_1us      (Clock_1us),
        .Rst_n          (Rst_n),
        .keyboard_write (keyboard_write),
        .keyboard_read  (keyboard_read),
        .kb_row_n       (kb_row_n),
        .cand           (r_cand),
        .kb_col         (kb_col),
        .sweep_done     (w_sweep_done),
        .sweep_result   (w_sweep)
    );

    // Codes beyond the configured matrix cannot arise; reject them outright.
    assign w_code_oob   = |(w_sweep.code >> c_code_w);
    assign w_single     = w_sweep.hit & ~w_sweep.multi & ~w_code_oob;
    assign w_sweep_code = w_sweep.code[c_code_w-1:0];
    assign w_cnt_inc    = r_cnt + c_cnt_w'(1);

    always_ff @(posedge Clock_1us or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= KB_IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cand  <= w_cand_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_accept    = 1'b0;
        if (w_sweep_done) begin
            case (r_state)
                KB_IDLE: begin
                    if (w_single) begin
                        w_cand_nxt = w_sweep_code;
                        w_cnt_nxt  = c_cnt_w'(1);
                        if (DEBOUNCE_SWEEPS <= 1) begin
                            w_state_nxt = KB_HELD;
                            w_accept    = 1'b1;
                        end else begin
                            w_state_nxt = KB_DEBOUNCE;
                        end
                    end
                end
                KB_DEBOUNCE: begin
                    if (w_single && (w_sweep_code == r_cand)) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == c_cnt_w'(DEBOUNCE_SWEEPS)) begin
                            w_state_nxt = KB_HELD;
                            w_accept    = 1'b1;
                        end
                    end else begin
                        w_state_nxt = KB_IDLE;
                    end
                end
                KB_HELD: begin
                    if (!w_sweep.cand_seen) begin
                        w_cnt_nxt   = c_cnt_w'(1);
                        w_state_nxt = (DEBOUNCE_SWEEPS <= 1) ? KB_IDLE : KB_RELEASE;
                    end
                end
                KB_RELEASE: begin
                    if (w_sweep.cand_seen) begin
                        w_state_nxt = KB_HELD;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == c_cnt_w'(DEBOUNCE_SWEEPS)) w_state_nxt = KB_IDLE;
                    end
                end
                default: w_state_nxt = KB_IDLE;
            endcase
        end
    end

    always_comb begin
        w_emit      = w_accept | w_repeat;
        w_emit_code = (r_state == KB_HELD) ? r_cand : w_sweep_code;
        key_held    = (r_state == KB_HELD) || (r_state == KB_RELEASE);
    end

`ifdef KEYBOARD_AUTOREPEAT_EN
    localparam int c_rpt_max = (REPEAT_DELAY_SWEEPS > REPEAT_RATE_SWEEPS) ?
                               REPEAT_DELAY_SWEEPS : REPEAT_RATE_SWEEPS;
    localparam int c_rpt_w   = $clog2(c_rpt_max+1);

    logic [c_rpt_w-1:0] r_rpt;
    logic [c_rpt_w-1:0] w_rpt_inc;
    logic               r_rpt_first;

    assign w_rpt_inc = r_rpt + c_rpt_w'(1);
    assign w_repeat  = w_sweep_done && (r_state == KB_HELD) && w_sweep.cand_seen &&
                       (w_rpt_inc == (r_rpt_first ? c_rpt_w'(REPEAT_DELAY_SWEEPS)
                                                  : c_rpt_w'(REPEAT_RATE_SWEEPS)));

    // Held outside HELD, so every entry into HELD starts a fresh delay.
    always_ff @(posedge Clock_1us or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rpt       <= '0;
            r_rpt_first <= 1'b1;
        end else if (w_sweep_done) begin
            if (r_state != KB_HELD) begin
                r_rpt       <= '0;
                r_rpt_first <= 1'b1;
            end else if (w_repeat) begin
                r_rpt       <= '0;
                r_rpt_first <= 1'b0;
            end else if (w_sweep.cand_seen) begin
                r_rpt <= w_rpt_inc;
            end
        end
    end
`else
    assign w_repeat = 1'b0;
`endif

    always_ff @(posedge Clock_1us or negedge Rst_n) begin
        if (!Rst_n) begin
            r_key_code    <= '0;
            r_key_valid   <= 1'b0;
            r_key_overrun <= 1'b0;
        end else begin
            if (key_ack && r_key_valid) begin
                r_key_valid   <= 1'b0;
                r_key_overrun <= 1'b0;
            end
            if (w_emit) begin
                if (!r_key_valid || key_ack) begin
                    r_key_code  <= w_emit_code;
                    r_key_valid <= 1'b1;
                end else begin
                    r_key_overrun <= 1'b1;
                end
            end
        end
    end

    assign key_code    = r_key_code;
    assign key_valid   = r_key_valid;
    assign key_overrun = r_key_overrun;

endmodule
`default_nettype wire

// File: tb/tb_keyboard_matrix_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_keyboard_matrix_scan
// Description : Self-checking bench for keyboard_matrix_scan with a key
//               matrix model and an expected-key scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keyboard_matrix_scan;

    localparam int COLS = 8;
    localparam int ROWS = 4;

    logic                 Clock_1us      = 1'b0;
    logic                 Rst_n          = 1'b0;
    logic                 keyboard_write = 1'b0;
    logic                 keyboard_read  = 1'b0;
    logic                 key_ack        = 1'b0;
    logic [ROWS-1:0]      kb_row_n;
    logic [2:0]           kb_col;
    logic [4:0]           key_code;
    logic                 key_valid;
    logic                 key_overrun;
    logic                 key_held;
    logic [COLS*ROWS-1:0] keys = '0;

    int   passed   = 0;
    int   total    = 0;
    bit   auto_ack = 1'b1;
    logic [4:0] exp_q[$];

    keyboard_matrix_scan #(
        .COLS                (COLS),
        .ROWS                (ROWS),
        .DEBOUNCE_SWEEPS     (3),
        .REPEAT_DELAY_SWEEPS (4),
        .REPEAT_RATE_SWEEPS  (2)
    ) dut (
        .Clock_1us      (Clock_1us),
        .Rst_n          (Rst_n),
        .keyboard_write (keyboard_write),
        .keyboard_read  (keyboard_read),
        .kb_row_n       (kb_row_n),
        .kb_col         (kb_col),
        .key_code       (key_code),
        .key_valid      (key_valid),
        .key_ack        (key_ack),
        .key_overrun    (key_overrun),
        .key_held       (key_held)
    );

    initial forever #5 Clock_1us = ~Clock_1us;

    // Matrix model: the driven column exposes its pressed keys as low rows.
    assign kb_row_n = ~keys[int'(kb_col)*ROWS +: ROWS];

    task automatic tick();
        logic [4:0] e;
        @(negedge Clock_1us);
        if (auto_ack) begin
            if (key_ack) begin
                key_ack = 1'b0;
            end else if (key_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_emit: got key_code %0d, required no key", key_code);
                end else begin
                    e = exp_q.pop_front();
                    if (key_code !== e)
                        $display("FAIL emit_code: got %0d, required %0d", key_code, e);
                    else
                        passed++;
                end
                key_ack = 1'b1;
            end
        end
    endtask

    // Leaves the bench at the negedge right after the read-edge posedge.
    task automatic col_to_read_edge();
        keyboard_write = 1'b1;
        tick();
        keyboard_write = 1'b0;
        repeat (4) tick();
        keyboard_read = 1'b1;
        tick();
        keyboard_read = 1'b0;
    endtask

    task automatic do_cols(input int n);
        for (int c = 0; c < n; c++) begin
            col_to_read_edge();
            tick();
        end
    endtask

    task automatic do_sweeps(input int n);
        for (int s = 0; s < n; s++) do_cols(COLS);
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        repeat (3) tick();
        total++; if (kb_col !== 3'd0) $display("FAIL reset_kb_col: got %0d, required 0", kb_col); else passed++;
        total++; if (key_code !== 5'd0) $display("FAIL reset_key_code: got %0d, required 0", key_code); else passed++;
        total++; if (key_valid !== 1'b0) $display("FAIL reset_key_valid: got %b, required 0", key_valid); else passed++;
        total++; if (key_overrun !== 1'b0) $display("FAIL reset_key_overrun: got %b, required 0", key_overrun); else passed++;
        total++; if (key_held !== 1'b0) $display("FAIL reset_key_held: got %b, required 0", key_held); else passed++;
        Rst_n = 1'b1;
        tick();
    endtask

    task automatic test_clean_press();
        keys = '0; keys[9] = 1'b1;
        exp_q.push_back(5'd9);
        do_sweeps(2);
        do_cols(COLS-1);
        col_to_read_edge();
        total++; if (key_valid !== 1'b0) $display("FAIL press_not_early: got %b, required 0", key_valid); else passed++;
        tick();
        total++; if (key_valid !== 1'b1) $display("FAIL press_valid_t1: got %b, required 1", key_valid); else passed++;
        total++; if (key_held !== 1'b1) $display("FAIL press_held: got %b, required 1", key_held); else passed++;
        do_sweeps(2);
        total++; if (key_held !== 1'b1) $display("FAIL press_still_held: got %b, required 1", key_held); else passed++;
        keys = '0;
        do_sweeps(3);
        total++; if (key_held !== 1'b0) $display("FAIL press_released: got %b, required 0", key_held); else passed++;
        total++; if (exp_q.size() !== 0) $display("FAIL press_missing_emit: got %0d pending, required 0", exp_q.size()); else passed++;
    endtask

    task automatic test_bounce();
        keys = '0; keys[9] = 1'b1; do_sweeps(1);
        keys = '0;                 do_sweeps(1);
        keys[9] = 1'b1;            do_sweeps(2);
        total++; if (key_held !== 1'b0) $display("FAIL bounce_early_held: got %b, required 0", key_held); else passed++;
        exp_q.push_back(5'd9);
        do_sweeps(1);
        total++; if (key_held !== 1'b1) $display("FAIL bounce_held: got %b, required 1", key_held); else passed++;
        keys = '0;
        do_sweeps(3);
        total++; if (exp_q.size() !== 0) $display("FAIL bounce_missing_emit: got %0d pending, required 0", exp_q.size()); else passed++;
    endtask

    task automatic test_ghosting();
        keys = '0; keys[0] = 1'b1; keys[5] = 1'b1;
        do_sweeps(4);
        total++; if (key_valid !== 1'b0) $display("FAIL ghost_valid: got %b, required 0", key_valid); else passed++;
        total++; if (key_held !== 1'b0) $display("FAIL ghost_held: got %b, required 0", key_held); else passed++;
        keys = '0;
        do_sweeps(1);
    endtask

    task automatic test_overrun();
        logic [4:0] e;
        auto_ack = 1'b0; key_ack = 1'b0;
        keys = '0; keys[3] = 1'b1; exp_q.push_back(5'd3); do_sweeps(3);
        keys = '0; do_sweeps(3);
        keys[7] = 1'b1; do_sweeps(3);
        keys = '0; do_sweeps(3);
        total++; if (key_valid !== 1'b1) $display("FAIL overrun_valid: got %b, required 1", key_valid); else passed++;
        total++; if (key_overrun !== 1'b1) $display("FAIL overrun_flag: got %b, required 1", key_overrun); else passed++;
        e = exp_q.pop_front();
        total++; if (key_code !== e) $display("FAIL overrun_code: got %0d, required %0d", key_code, e); else passed++;
        key_ack = 1'b1; tick(); key_ack = 1'b0; tick();
        total++; if (key_valid !== 1'b0) $display("FAIL ack_clears_valid: got %b, required 0", key_valid); else passed++;
        total++; if (key_overrun !== 1'b0) $display("FAIL ack_clears_overrun: got %b, required 0", key_overrun); else passed++;

        keys[12] = 1'b1; exp_q.push_back(5'd12); do_sweeps(3);
        keys = '0; do_sweeps(3);
        e = exp_q.pop_front();
        total++; if (key_code !== e) $display("FAIL pre_ack_code: got %0d, required %0d", key_code, e); else passed++;
        keys[20] = 1'b1; exp_q.push_back(5'd20);
        do_sweeps(2);
        do_cols(COLS-1);
        col_to_read_edge();
        key_ack = 1'b1;
        tick();
        key_ack = 1'b0;
        e = exp_q.pop_front();
        total++; if (key_valid !== 1'b1) $display("FAIL ack_emit_valid: got %b, required 1", key_valid); else passed++;
        total++; if (key_code !== e) $display("FAIL ack_emit_code: got %0d, required %0d", key_code, e); else passed++;
        total++; if (key_overrun !== 1'b0) $display("FAIL ack_emit_overrun: got %b, required 0", key_overrun); else passed++;
        key_ack = 1'b1; tick(); key_ack = 1'b0; tick();
        keys = '0;
        do_sweeps(3);
        auto_ack = 1'b1;
    endtask

    task automatic test_unarmed_read();
        keys = '0;
        for (int c = 0; c < COLS; c++) begin
            keyboard_read = 1'b1; tick(); keyboard_read = 1'b0; tick();
            keyboard_write = 1'b1; tick(); keyboard_write = 1'b0; tick();
            total++; if (kb_col !== 3'(c)) $display("FAIL unarmed_col: got %0d, required %0d", kb_col, c); else passed++;
            repeat (3) tick();
            keyboard_read = 1'b1; tick(); keyboard_read = 1'b0; tick();
        end
    endtask

    task automatic test_reset_mid_sweep();
        auto_ack = 1'b0;
        keys = '0; keys[9] = 1'b1;
        do_sweeps(3);
        total++; if (key_valid !== 1'b1) $display("FAIL pend_valid: got %b, required 1", key_valid); else passed++;
        do_cols(3);
        Rst_n = 1'b0;
        #1;
        total++; if (kb_col !== 3'd0) $display("FAIL midrst_kb_col: got %0d, required 0", kb_col); else passed++;
        total++; if (key_valid !== 1'b0) $display("FAIL midrst_valid: got %b, required 0", key_valid); else passed++;
        total++; if (key_code !== 5'd0) $display("FAIL midrst_code: got %0d, required 0", key_code); else passed++;
        total++; if (key_held !== 1'b0) $display("FAIL midrst_held: got %b, required 0", key_held); else passed++;
        tick();
        Rst_n = 1'b1;
        tick();
        auto_ack = 1'b1;
        keys = '0; keys[5] = 1'b1;
        exp_q.push_back(5'd5);
        do_sweeps(3);
        keys = '0;
        do_sweeps(3);
        total++; if (exp_q.size() !== 0) $display("FAIL post_reset_emit: got %0d pending, required 0", exp_q.size()); else passed++;
    endtask

    task automatic test_autorepeat();
        keys = '0; keys[9] = 1'b1;
        for (int s = 1; s <= 12; s++) begin
            if (s == 3) exp_q.push_back(5'd9);
`ifdef KEYBOARD_AUTOREPEAT_EN
            if (s == 7 || s == 9 || s == 11) exp_q.push_back(5'd9);
`endif
            do_sweeps(1);
        end
        total++; if (key_held !== 1'b1) $display("FAIL repeat_held: got %b, required 1", key_held); else passed++;
        keys = '0;
        do_sweeps(3);
        total++; if (exp_q.size() !== 0) $display("FAIL repeat_missing_emit: got %0d pending, required 0", exp_q.size()); else passed++;
        total++; if (key_held !== 1'b0) $display("FAIL repeat_released: got %b, required 0", key_held); else passed++;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_ghosting();
        test_overrun();
        test_unarmed_read();
        test_reset_mid_sweep();
        test_autorepeat();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keyboard_matrix_scan.md
# keyboard_matrix_scan

Consumes the sequencer's `keyboard_write` / `keyboard_read` strobes to scan the emulator's key matrix one column per sequencer frame. It drives the column index to the column decoder and samples the active-low row lines. It debounces complete sweeps and delivers single key codes to the CPU-side logic through a valid/ack handshake. Multi-key sweeps are rejected (ghosting).

## Interface
- `COLS`, 8: matrix columns.
- `ROWS`, 4: matrix rows.
- `DEBOUNCE_SWEEPS`, 3: consecutive identical sweeps needed to accept a press or a release (≥1).
- `REPEAT_DELAY_SWEEPS`, 40: autorepeat first delay, in sweeps.
- `REPEAT_RATE_SWEEPS`, 8: autorepeat period, in sweeps.
- `Clock_1us`, in, 1: sole clock.
- `Rst_n`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `keyboard_write`, in, 1: sequencer column-drive strobe.
- `keyboard_read`, in, 1: sequencer row-sample strobe.
- `kb_row_n`, in, ROWS: raw row lines; 0 means pressed; asynchronous.
- `kb_col`, out, $clog2(COLS): column index to the decoder.
- `key_code`, out, $clog2(COLS*ROWS): accepted key, computed as col*ROWS+row.
- `key_valid`, out, 1: `key_code` holds an unconsumed key.
- `key_ack`, in, 1: consumer takes the key.
- `key_overrun`, out, 1: sticky; a key was dropped while `key_valid` was high.
- `key_held`, out, 1: debounced key currently down (FSM in HELD or RELEASE).

## Operation
- `kb_row_n` passes through a 2-FF synchronizer; synchronizer reset value is all ones.
- Strobes are edge-detected internally. Action occurs at the posedge where the strobe is 1 and its registered copy is 0.
- **Write edge:**
  - `kb_col <= col_idx`.
  - Set `armed`.
- **Read edge with `armed`:**
  - Sample rows for `kb_col` and clear `armed`.
  - Advance `col_idx`, wrapping COLS-1→0.
- **Read edge without `armed`:** ignored entirely; no sample, no advance.
- **Sweep accumulator:** tracks, across columns 0..COLS-1:
  - `hit`: any key pressed.
  - `multi`: more than one key pressed.
  - `code`: lowest pressed index.
  - `cand_seen`: the FSM candidate key was pressed.
- On the read edge of column COLS-1, the sweep result is registered and the accumulator is cleared.
- **FSM** (`IDLE`, `DEBOUNCE`, `HELD`, `RELEASE`) steps once per completed sweep:
  - `IDLE`:
    - single-key sweep → `DEBOUNCE`, cand=code, cnt=1.
    - none or multi → stay.
  - `DEBOUNCE`:
    - single sweep with code==cand → cnt+1.
    - when cnt reaches DEBOUNCE_SWEEPS → emit, `HELD`.
    - otherwise → `IDLE`.
  - `HELD`:
    - `cand_seen` → stay.
    - else → `RELEASE`, cnt=1.
  - `RELEASE`:
    - `cand_seen` → `HELD`.
    - else cnt+1; at DEBOUNCE_SWEEPS → `IDLE`.
- DEBOUNCE_SWEEPS=1: emission happens on the `IDLE` sweep itself (`IDLE`→`HELD`).
- **Emit:**
  - If `key_valid`=0, or `key_ack`=1 in the same cycle: load `key_code`, `key_valid`=1.
  - Otherwise: drop the key, set `key_overrun`.
- **Ack:**
  - `key_ack` with `key_valid` clears `key_valid` and `key_overrun`, unless an emit occurs in the same cycle, in which case `key_valid` stays 1.
  - `key_ack` while `key_valid`=0 has no effect.

## Timing
- **Reset values:**
  - `kb_col`=0, `key_code`=0, `key_valid`=0, `key_overrun`=0, `key_held`=0.
  - FSM `IDLE`, `col_idx`=0, `armed`=0.
  - Accumulator and counters cleared.
- Reset mid-sweep discards the partial sweep and any pending key.
- Row sample uses the synchronizer output at the read-edge posedge T. Rows must be stable ≥2 cycles before the read strobe; the sequencer frame guarantees this.
- Sweep result is registered at T. FSM and outputs update at T+1, so `key_valid` rises visibly after posedge T+1.
- Simultaneous write and read edges: read is processed first using the old `kb_col`, then write latches the new `col_idx`, and `armed` ends set.

## Configuration
- Macro: `KEYBOARD_AUTOREPEAT_EN`.
- **Defined:** in `HELD`, a repeat counter counts sweeps.
  - First re-emit of cand after REPEAT_DELAY_SWEEPS.
  - Then every REPEAT_RATE_SWEEPS.
  - Counter is reset on entry to `HELD` (including from `RELEASE`).
- **Undefined:** exactly one emit per press; repeat counter not built.

## Structure
- Shared package `keyboard_pkg`:
  - FSM state enum `kb_state_t`.
  - Sweep result struct (`hit`, `multi`, `code`, `cand_seen`).
- One sub-module, `keyboard_sweep`: synchronizer, strobe edge detection, `armed`, `col_idx`/`kb_col`, sweep accumulator.
- FSM and handshake stay in the top.

## Test plan
- **Clean press:** hold key col 2 row 1 for 5 sweeps (DEBOUNCE_SWEEPS=3) → exactly one `key_valid` with `key_code`=9 one cycle after the 3rd sweep's final read edge; `key_held`=1.
- **Bounce:** key 9 present in sweeps 1 and 3, absent in sweep 2 → no emit until 3 consecutive clean sweeps.
- **Ghosting:** keys 0 and 5 pressed together → FSM stays `IDLE`, `key_valid` stays 0.
- **Overrun:** two debounced presses (keys 3 then 7) with no ack → `key_code`=3, `key_overrun`=1; ack clears both. Ack in the same cycle as an emit → new code loaded, `key_valid` stays 1.
- **Unarmed read:** read strobe without a preceding write → `col_idx` unchanged, no sample. Reset asserted mid-sweep → all outputs return to reset values within the same cycle.
- **With `KEYBOARD_AUTOREPEAT_EN`** (delay 4, rate 2): key held 12 sweeps → emits at acceptance, then +4, +6, +8 sweeps. Without the macro → a single emit.
